tc_pl_bus_seq: RTL and testbench
================================

Name: tc_pl_bus_seq

Overview:
Transaction sequencer between the PL bus TX buffer (FWFT, 9-bit words) and the shared byte-wide SPI master.
- Parses header words into per-device frames.
- Drives the device chip-select vector consumed by the CSN router.
- Meters data bytes into the SPI engine on its request handshake.
- Reports sticky protocol errors to the PS-visible status bus.

Parameters:
DW, 8, SPI byte width (equals buffer read width AGP0_25)
FW, 9, TX buffer word width (AGP0_23); bit FW-1 = header flag
NDEV, 5, number of SPI devices (ADC0, FDA0, DAC0, DAC1, LPL0)
TMO, 1023, starvation timeout in clk cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
txb_data  in  FW  TX buffer head word, valid when txb_empty=0 (first-word fall-through)
txb_empty  in  1  TX buffer empty
txb_req  out  1  one-cycle pop strobe for the TX buffer
spi_tx_idle  in  1  SPI engine idle, CSN high
spi_tx_dreq  in  1  SPI engine requests the next byte (one-cycle pulse)
spi_tx_valid  out  1  one-cycle byte strobe to the SPI engine
spi_tx_data  out  DW  byte to the SPI engine, held stable until the next strobe
dev_sel  out  NDEV  one-hot active device select, 0 = none
busy  out  1  high while state != IDLE
err_code  out  2  sticky error code: 0 none, 1 stray data, 2 bad device, 3 underrun/header-in-frame
err_clr  in  1  clears err_code

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, on rst. On reset: state IDLE; txb_req, spi_tx_valid, spi_tx_data, dev_sel, busy and err_code are all 0.
- Header word format: bit8=1; [7:3] = length-1, giving 1..32 data bytes; [2:0] = device index. Data word format: bit8=0; [7:0] = byte.
- IDLE:
  - If !txb_empty and the head word is a header: pop it; latch dev and rem=len; go to ARM.
  - If the head word is data: pop it, discard it, set err=1, stay in IDLE.
  - If dev>=NDEV: pop, set err=2, go to FLUSH with rem=len.
- ARM: wait for spi_tx_idle=1, then set dev_sel[dev]=1 and go to LOAD. dev_sel is stable for the whole frame.
- LOAD: wait for !txb_empty.
  - If the head word is data: pop it. On the same cycle spi_tx_data<=byte and spi_tx_valid=1 (registered, so visible next cycle). rem--. If rem reaches 0, go to DRAIN; otherwise go to WREQ.
  - If the head word is a header: set err=3, do not pop, go to DRAIN (frame truncated).
- WREQ: on spi_tx_dreq, go to LOAD. Latency from dreq to valid is 2 cycles when data is present.
- Underrun: if spi_tx_idle goes high while in LOAD or WREQ with rem>0, set err=3 and go to FLUSH.
- DRAIN: wait for spi_tx_idle=0 (seen once), then spi_tx_idle=1. Then clear dev_sel and go to IDLE.
- FLUSH: pop and discard data words until rem=0. Stop early, without popping, if the head word is a header. Then clear dev_sel and go to IDLE.
- Pops: at most one per cycle. txb_req is never asserted while txb_empty=1.
- err_code: sticky and never overwritten by a later error. err_clr clears it; if err_clr and a new error occur on the same cycle, the new error wins.
- Reset mid-frame: dev_sel drops on the reset edge. The SPI engine shares rst, so no partial-frame recovery is needed.

Optional Feature:
TC_PL_BUS_SEQ_TIMEOUT_EN:
- When defined: a counter runs in ARM, LOAD and WREQ and resets on any state change. At TMO cycles it sets err=3, clears dev_sel and returns to IDLE without flushing.
- When not defined: those states wait indefinitely, and no counter logic is synthesised.

Decomposition:
- Shared package/include tc_pl_bus_pkg holds: the state encoding; error code constants; device index constants (ADC0=0, FDA0=1, DAC0=2, DAC1=3, LPL0=4); header field positions (flag bit 8, length [7:3], device [2:0]).
- Optional sub-module tc_pl_bus_seq_tmo holds the timeout counter. Everything else stays flat in one module.

Test Plan:
- Header 0x10A (dev 2, len 2), data 0x0A5, 0x03C, SPI model pulsing dreq -> dev_sel=00100; spi_tx_data 0xA5 then 0x3C; exactly 2 valid strobes; busy falls after idle returns; err=0.
- Data 0x055 with no header while IDLE -> popped, no valid strobe, err_code=1; pulse err_clr -> 0.
- Header 0x107 (dev 7, len 1) followed by 0x011 -> both popped, dev_sel stays 0, err=2.
- Header 0x1F8 (dev 0, len 32), only 3 data words, SPI ends the frame -> err=3, remaining words flushed, dev_sel=0, state IDLE.
- rst asserted mid-frame after byte 2 -> next cycle all outputs 0; a following frame 0x101,0x0FF completes normally.
- With TC_PL_BUS_SEQ_TIMEOUT_EN and TMO=16: header with no data -> err=3 and return to IDLE after 16 cycles in LOAD.

Source files
------------

// File: rtl/tc_pl_bus_pkg.sv
// Shared definitions for the PL bus transaction sequencer: FSM state
// encoding, sticky error codes, SPI device indices and the header word
// field layout of the TX buffer.
package tc_pl_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ARM   = 3'd1,
      ST_LOAD  = 3'd2,
      ST_WREQ  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_FLUSH = 3'd5
   } seq_state_t;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_STRAY    = 2'd1;
   localparam logic [1:0] ERR_BAD_DEV  = 2'd2;
   localparam logic [1:0] ERR_UNDERRUN = 2'd3;

   localparam logic [2:0] DEV_ADC0 = 3'd0;
   localparam logic [2:0] DEV_FDA0 = 3'd1;
   localparam logic [2:0] DEV_DAC0 = 3'd2;
   localparam logic [2:0] DEV_DAC1 = 3'd3;
   localparam logic [2:0] DEV_LPL0 = 3'd4;

   localparam int HDR_FLAG_BIT = 8;
   localparam int HDR_LEN_MSB  = 7;
   localparam int HDR_LEN_LSB  = 3;
   localparam int HDR_DEV_MSB  = 2;
   localparam int HDR_DEV_LSB  = 0;

   // Frame length in bytes; the header carries length-1 so 1..32 fits in 5 bits.
   function automatic logic [5:0] hdr_len(input logic [8:0] word);
      return {1'b0, word[HDR_LEN_MSB:HDR_LEN_LSB]} + 6'd1;
   endfunction

   function automatic logic [2:0] hdr_dev(input logic [8:0] word);
      return word[HDR_DEV_MSB:HDR_DEV_LSB];
   endfunction

endpackage

// File: rtl/tc_pl_bus_seq_if.sv
// TX buffer read port and SPI engine byte handshake, bundled so the
// sequencer (master) and its peers (slave) share one connection.
interface tc_pl_bus_seq_if #(
   parameter int DW = 8,
   parameter int FW = 9
);
   logic [FW-1:0] txb_data;
   logic          txb_empty;
   logic          txb_req;
   logic          spi_tx_idle;
   logic          spi_tx_dreq;
   logic          spi_tx_valid;
   logic [DW-1:0] spi_tx_data;

   modport master (
      input  txb_data, txb_empty, spi_tx_idle, spi_tx_dreq,
      output txb_req, spi_tx_valid, spi_tx_data
   );

   modport slave (
      output txb_data, txb_empty, spi_tx_idle, spi_tx_dreq,
      input  txb_req, spi_tx_valid, spi_tx_data
   );
endinterface

// File: rtl/tc_pl_bus_seq_tmo.sv
// Starvation timer for the sequencer: counts cycles spent in a waiting
// state and flags expiry on the TMO-th consecutive cycle in that state.
module tc_pl_bus_seq_tmo #(
   parameter int TMO = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic restart,
   output logic expire
);
   localparam int CW = $clog2(TMO + 1);

   logic [CW-1:0] cnt;

   assign expire = run && (cnt == CW'(TMO - 1));

   // Count while a waiting state persists; any state change starts over.
   always_ff @(posedge clk) begin
      if (rst || !run || restart) begin
         cnt <= '0;
      end else if (!expire) begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/tc_pl_bus_seq.sv
// Transaction sequencer between the FWFT TX buffer and the shared SPI
// master. Header words open a frame for one device, data words are metered
// into the SPI engine on its request pulses, and protocol faults are
// latched in a sticky error code.
// Optional build macro TC_PL_BUS_SEQ_TIMEOUT_EN adds a starvation timeout
// for the ARM/LOAD/WREQ waits (parameter TMO).
// FLUSH also ends when the buffer runs empty, so a short frame after an
// error cannot stall the sequencer waiting for words that never come.
module tc_pl_bus_seq
   import tc_pl_bus_pkg::*;
#(
   parameter int DW   = 8,
   parameter int FW   = 9,
   parameter int NDEV = 5
`ifdef TC_PL_BUS_SEQ_TIMEOUT_EN
   ,
   parameter int TMO  = 1023
`endif
) (
   input  logic              clk,
   input  logic              rst,
   tc_pl_bus_seq_if.master   bus,
   output logic [NDEV-1:0]   dev_sel,
   output logic              busy,
   output logic [1:0]        err_code,
   input  logic              err_clr
);

   seq_state_t      state_q, state_d;
   logic [2:0]      dev_q, dev_d;
   logic [5:0]      rem_q, rem_d;
   logic [NDEV-1:0] dev_sel_d;
   logic [DW-1:0]   tx_data_q, tx_data_d;
   logic            tx_valid_q, tx_valid_d;
   logic            drain_seen_q, drain_seen_d;
   logic            idle_q;
   logic            pop;
   logic [1:0]      err_new;

   logic            head_hdr;
   logic [5:0]      head_len;
   logic [2:0]      head_dev;
   logic            head_bad;
   logic            underrun;
   logic [NDEV-1:0] dev_onehot;

   assign head_hdr   = bus.txb_data[FW-1];
   assign head_len   = hdr_len(bus.txb_data);
   assign head_dev   = hdr_dev(bus.txb_data);
   assign head_bad   = (32'(head_dev) >= NDEV);
   assign dev_onehot = NDEV'(1) << dev_q;
   assign underrun   = bus.spi_tx_idle && !idle_q && (rem_q != 6'd0);

   assign bus.txb_req      = pop && !rst;
   assign bus.spi_tx_valid = tx_valid_q;
   assign bus.spi_tx_data  = tx_data_q;
   assign busy             = (state_q != ST_IDLE);

`ifdef TC_PL_BUS_SEQ_TIMEOUT_EN
   logic tmo_run;
   logic tmo_expire;

   assign tmo_run = (state_q == ST_ARM) || (state_q == ST_LOAD) || (state_q == ST_WREQ);

   tc_pl_bus_seq_tmo #(.TMO(TMO)) u_tmo (
      .clk     (clk),
      .rst     (rst),
      .run     (tmo_run),
      .restart (state_d != state_q),
      .expire  (tmo_expire)
   );
`endif

   // Next-state, buffer pop, SPI byte load and error detection.
   always_comb begin
      state_d      = state_q;
      dev_d        = dev_q;
      rem_d        = rem_q;
      dev_sel_d    = dev_sel;
      tx_data_d    = tx_data_q;
      tx_valid_d   = 1'b0;
      drain_seen_d = drain_seen_q;
      pop          = 1'b0;
      err_new      = ERR_NONE;

      case (state_q)
         ST_IDLE: begin
            if (!bus.txb_empty) begin
               pop = 1'b1;
               if (!head_hdr) begin
                  err_new = ERR_STRAY;
               end else if (head_bad) begin
                  err_new = ERR_BAD_DEV;
                  rem_d   = head_len;
                  state_d = ST_FLUSH;
               end else begin
                  dev_d   = head_dev;
                  rem_d   = head_len;
                  state_d = ST_ARM;
               end
            end
         end
         ST_ARM: begin
            if (bus.spi_tx_idle) begin
               dev_sel_d = dev_onehot;
               state_d   = ST_LOAD;
            end
         end
         ST_LOAD: begin
            if (underrun) begin
               err_new = ERR_UNDERRUN;
               state_d = ST_FLUSH;
            end else if (!bus.txb_empty) begin
               if (head_hdr) begin
                  err_new      = ERR_UNDERRUN;
                  drain_seen_d = 1'b0;
                  state_d      = ST_DRAIN;
               end else begin
                  pop        = 1'b1;
                  tx_data_d  = bus.txb_data[DW-1:0];
                  tx_valid_d = 1'b1;
                  rem_d      = rem_q - 6'd1;
                  if (rem_q == 6'd1) begin
                     drain_seen_d = 1'b0;
                     state_d      = ST_DRAIN;
                  end else begin
                     state_d = ST_WREQ;
                  end
               end
            end
         end
         ST_WREQ: begin
            if (underrun) begin
               err_new = ERR_UNDERRUN;
               state_d = ST_FLUSH;
            end else if (bus.spi_tx_dreq) begin
               state_d = ST_LOAD;
            end
         end
         ST_DRAIN: begin
            if (!bus.spi_tx_idle) begin
               drain_seen_d = 1'b1;
            end else if (drain_seen_q) begin
               dev_sel_d = '0;
               state_d   = ST_IDLE;
            end
         end
         ST_FLUSH: begin
            if (rem_q == 6'd0 || bus.txb_empty || head_hdr) begin
               dev_sel_d = '0;
               state_d   = ST_IDLE;
            end else begin
               pop   = 1'b1;
               rem_d = rem_q - 6'd1;
            end
         end
         default: begin
            dev_sel_d = '0;
            state_d   = ST_IDLE;
         end
      endcase

`ifdef TC_PL_BUS_SEQ_TIMEOUT_EN
      if (tmo_expire) begin
         pop        = 1'b0;
         tx_data_d  = tx_data_q;
         tx_valid_d = 1'b0;
         rem_d      = rem_q;
         err_new    = ERR_UNDERRUN;
         dev_sel_d  = '0;
         state_d    = ST_IDLE;
      end
`endif
   end

   // Sequencer state, frame bookkeeping and registered SPI byte strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         dev_q        <= '0;
         rem_q        <= '0;
         dev_sel      <= '0;
         tx_data_q    <= '0;
         tx_valid_q   <= 1'b0;
         drain_seen_q <= 1'b0;
         idle_q       <= 1'b1;
      end else begin
         state_q      <= state_d;
         dev_q        <= dev_d;
         rem_q        <= rem_d;
         dev_sel      <= dev_sel_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         drain_seen_q <= drain_seen_d;
         idle_q       <= bus.spi_tx_idle;
      end
   end

   // Sticky error: first error holds until cleared; a new error beats a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_code <= ERR_NONE;
      end else if (err_new != ERR_NONE && (err_code == ERR_NONE || err_clr)) begin
         err_code <= err_new;
      end else if (err_clr) begin
         err_code <= ERR_NONE;
      end
   end

endmodule

// File: tb/tb_tc_pl_bus_seq.sv
// Directed and randomized bench for the PL bus sequencer. A queue models
// the FWFT TX buffer and a small behavioural SPI engine answers each byte
// with a request pulse and ends the frame when bytes stop arriving.
module tb_tc_pl_bus_seq;

   localparam int SHIFT_CYC = 4;
   localparam int WAIT_CYC  = 6;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] dev_sel;
   logic       busy;
   logic [1:0] err_code;
   logic       err_clr;

   tc_pl_bus_seq_if #(.DW(8), .FW(9)) bus ();

   tc_pl_bus_seq #(
      .DW   (8),
      .FW   (9),
      .NDEV (5)
`ifdef TC_PL_BUS_SEQ_TIMEOUT_EN
      ,
      .TMO  (16)
`endif
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .dev_sel  (dev_sel),
      .busy     (busy),
      .err_code (err_code),
      .err_clr  (err_clr)
   );

   always #5 clk = ~clk;

   logic [8:0] fifo_q[$];
   logic [7:0] log_q[$];
   logic [4:0] sel_or;
   int         n_cmp = 0;
   int         n_err = 0;
   bit         eng_shift = 0;
   bit         eng_wait  = 0;
   int         eng_cnt   = 0;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh_fifo();
      bus.txb_empty = (fifo_q.size() == 0);
      bus.txb_data  = (fifo_q.size() == 0) ? 9'h000 : fifo_q[0];
   endtask

   task automatic apply_stimulus(input logic [8:0] w);
      fifo_q.push_back(w);
      refresh_fifo();
   endtask

   function automatic logic [31:0] logged(input int i);
      return (i < log_q.size()) ? {24'd0, log_q[i]} : 32'hFFFF_FFFF;
   endfunction

   task automatic start_test();
      log_q.delete();
      sel_or = '0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      bit done;
      done = 0;
      for (int i = 0; i < max_cyc && !done; i++) begin
         @(negedge clk);
         done = !busy && fifo_q.size() == 0 && bus.spi_tx_idle && !eng_shift && !eng_wait;
      end
      check_output(tag, done, 1);
   endtask

   task automatic clear_err();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   // TX buffer pops, SPI engine behaviour and strobe logging.
   initial begin
      logic       pop_s, val_s, rst_s;
      logic [7:0] dat_s;
      logic [4:0] sel_s;
      forever begin
         @(posedge clk);
         pop_s = bus.txb_req;
         val_s = bus.spi_tx_valid;
         dat_s = bus.spi_tx_data;
         sel_s = dev_sel;
         rst_s = rst;
         #1;
         bus.spi_tx_dreq = 1'b0;
         if (rst_s) begin
            fifo_q.delete();
            eng_shift       = 0;
            eng_wait        = 0;
            bus.spi_tx_idle = 1'b1;
         end else begin
            sel_or = sel_or | sel_s;
            if (pop_s) begin
               check_output("pop_nonempty", fifo_q.size() != 0, 1);
               if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            if (val_s) begin
               log_q.push_back(dat_s);
               eng_shift       = 1;
               eng_wait        = 0;
               eng_cnt         = SHIFT_CYC;
               bus.spi_tx_idle = 1'b0;
            end else if (eng_shift) begin
               eng_cnt--;
               if (eng_cnt == 0) begin
                  eng_shift       = 0;
                  eng_wait        = 1;
                  eng_cnt         = WAIT_CYC;
                  bus.spi_tx_dreq = 1'b1;
               end
            end else if (eng_wait) begin
               eng_cnt--;
               if (eng_cnt == 0) begin
                  eng_wait        = 0;
                  bus.spi_tx_idle = 1'b1;
               end
            end
         end
         refresh_fifo();
      end
   end

   // Directed scenarios followed by random frames.
   initial begin
      logic [7:0] exp_q[$];
      int         dev, len;
      bit         got;

      rst             = 1'b1;
      err_clr         = 1'b0;
      bus.spi_tx_idle = 1'b1;
      bus.spi_tx_dreq = 1'b0;
      refresh_fifo();
      repeat (3) @(negedge clk);
      check_output("rst_txb_req", bus.txb_req, 0);
      check_output("rst_valid", bus.spi_tx_valid, 0);
      check_output("rst_data", bus.spi_tx_data, 0);
      check_output("rst_dev_sel", dev_sel, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_err", err_code, 0);
      rst = 1'b0;

      $display("[TB] basic frame to DAC0");
      start_test();
      apply_stimulus(9'h10A);
      apply_stimulus(9'h0A5);
      apply_stimulus(9'h03C);
      wait_done("t1_done", 400);
      check_output("t1_count", log_q.size(), 2);
      check_output("t1_byte0", logged(0), 32'hA5);
      check_output("t1_byte1", logged(1), 32'h3C);
      check_output("t1_sel", sel_or, 5'b00100);
      check_output("t1_dev_sel_end", dev_sel, 0);
      check_output("t1_err", err_code, 0);

      $display("[TB] stray data word");
      start_test();
      apply_stimulus(9'h055);
      wait_done("t2_done", 50);
      check_output("t2_count", log_q.size(), 0);
      check_output("t2_err", err_code, 1);
      clear_err();
      check_output("t2_err_clr", err_code, 0);

      $display("[TB] bad device index");
      start_test();
      apply_stimulus(9'h107);
      apply_stimulus(9'h011);
      wait_done("t3_done", 50);
      check_output("t3_count", log_q.size(), 0);
      check_output("t3_sel", sel_or, 0);
      check_output("t3_err", err_code, 2);
      clear_err();

      $display("[TB] bad device flush then valid frame");
      start_test();
      apply_stimulus(9'h117);
      apply_stimulus(9'h001);
      apply_stimulus(9'h002);
      apply_stimulus(9'h003);
      apply_stimulus(9'h101);
      apply_stimulus(9'h0EE);
      wait_done("t3b_done", 400);
      check_output("t3b_count", log_q.size(), 1);
      check_output("t3b_byte0", logged(0), 32'hEE);
      check_output("t3b_sel", sel_or, 5'b00010);
      check_output("t3b_err", err_code, 2);
      clear_err();

      $display("[TB] flush stops at next header");
      start_test();
      apply_stimulus(9'h11F);
      apply_stimulus(9'h044);
      apply_stimulus(9'h100);
      apply_stimulus(9'h077);
      wait_done("t3c_done", 400);
      check_output("t3c_count", log_q.size(), 1);
      check_output("t3c_byte0", logged(0), 32'h77);
      check_output("t3c_sel", sel_or, 5'b00001);
      check_output("t3c_err", err_code, 2);
      clear_err();

      $display("[TB] underrun on long frame");
      start_test();
      apply_stimulus(9'h1F8);
      apply_stimulus(9'h0A1);
      apply_stimulus(9'h0B2);
      apply_stimulus(9'h0C3);
      wait_done("t4_done", 600);
      check_output("t4_count", log_q.size(), 3);
      check_output("t4_byte2", logged(2), 32'hC3);
      check_output("t4_sel", sel_or, 5'b00001);
      check_output("t4_dev_sel_end", dev_sel, 0);
      check_output("t4_busy", busy, 0);
      check_output("t4_err", err_code, 3);
      clear_err();

      $display("[TB] header inside frame");
      start_test();
      apply_stimulus(9'h112);
      apply_stimulus(9'h0AA);
      apply_stimulus(9'h103);
      apply_stimulus(9'h0BB);
      wait_done("t4b_done", 600);
      check_output("t4b_count", log_q.size(), 2);
      check_output("t4b_byte0", logged(0), 32'hAA);
      check_output("t4b_byte1", logged(1), 32'hBB);
      check_output("t4b_sel", sel_or, 5'b01100);
      check_output("t4b_err", err_code, 3);
      clear_err();

      $display("[TB] reset mid-frame");
      start_test();
      apply_stimulus(9'h11A);
      apply_stimulus(9'h011);
      apply_stimulus(9'h022);
      apply_stimulus(9'h033);
      apply_stimulus(9'h044);
      got = 0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = (log_q.size() >= 2);
      end
      check_output("t5_two_bytes", got, 1);
      rst = 1'b1;
      @(negedge clk);
      check_output("t5_txb_req", bus.txb_req, 0);
      check_output("t5_valid", bus.spi_tx_valid, 0);
      check_output("t5_data", bus.spi_tx_data, 0);
      check_output("t5_dev_sel", dev_sel, 0);
      check_output("t5_busy", busy, 0);
      check_output("t5_err", err_code, 0);
      rst = 1'b0;
      start_test();
      apply_stimulus(9'h101);
      apply_stimulus(9'h0FF);
      wait_done("t5_done", 400);
      check_output("t5_count", log_q.size(), 1);
      check_output("t5_byte0", logged(0), 32'hFF);
      check_output("t5_sel", sel_or, 5'b00010);
      check_output("t5_err_after", err_code, 0);

`ifdef TC_PL_BUS_SEQ_TIMEOUT_EN
      $display("[TB] starvation timeout");
      start_test();
      apply_stimulus(9'h100);
      wait_done("t6_done", 200);
      check_output("t6_count", log_q.size(), 0);
      check_output("t6_sel", sel_or, 5'b00001);
      check_output("t6_dev_sel_end", dev_sel, 0);
      check_output("t6_err", err_code, 3);
      clear_err();
`endif

      $display("[TB] random frames");
      for (int f = 0; f < 12; f++) begin
         start_test();
         exp_q.delete();
         dev = $urandom_range(0, 4);
         len = $urandom_range(1, 8);
         apply_stimulus({1'b1, 5'(len - 1), 3'(dev)});
         for (int b = 0; b < len; b++) begin
            exp_q.push_back(8'($urandom));
            apply_stimulus({1'b0, exp_q[b]});
         end
         wait_done("rnd_done", 600);
         check_output("rnd_count", log_q.size(), len);
         for (int b = 0; b < len; b++) begin
            check_output("rnd_byte", logged(b), {24'd0, exp_q[b]});
         end
         check_output("rnd_sel", sel_or, 32'(1) << dev);
         check_output("rnd_err", err_code, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
